powlib_cdc_hsrx: RTL and testbench

- Receiving (responder) end of a 2-phase toggle handshake used to move a W-bit word into the clk domain from an unrelated clock domain.
- Synchronizes the sender's request toggle and captures the held data word.
- Presents the word downstream on a valid/ready interface.
- Returns an acknowledge toggle that the sender synchronizes on its side.

---
 rtl/powlib_cdc_pkg.sv | 15 +
 rtl/powlib_cdc_sync.sv | 37 +++
 rtl/powlib_cdc_hsrx.sv | 99 +++++++++
 tb/tb_powlib_cdc_hsrx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/powlib_cdc_pkg.sv
// Shared definitions for the powlib toggle-handshake CDC blocks.
package powlib_cdc_pkg;

  // Responder FSM: IDLE has no word presented, HOLD presents dout.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cdc_state_e;

  // Default and legal range of synchronizer depth on toggle paths.
  localparam int CDC_S_DEF = 2;
  localparam int CDC_S_MIN = 2;
  localparam int CDC_S_MAX = 4;

endpackage

// File: rtl/powlib_cdc_sync.sv
// S-stage single-bit synchronizer, async active-low reset to 0.
// Shared by the receiver (req path) and the transmitter (ack path).
module powlib_cdc_sync
  import powlib_cdc_pkg::*;
#(
  parameter int S = CDC_S_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (S < CDC_S_MIN || S > CDC_S_MAX) begin : g_bad_depth
    $error("powlib_cdc_sync: S=%0d outside legal range %0d..%0d", S, CDC_S_MIN, CDC_S_MAX);
  end

  logic [S-1:0] sync_q;
  logic [S-1:0] sync_d;

  // Shift the asynchronous input one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[S-2:0], d};
  end

  // Synchronizer flops; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[S-1];

endmodule

// File: rtl/powlib_cdc_hsrx.sv
// Responder end of a 2-phase toggle handshake: synchronizes req_tgl,
// captures the sender's held word, presents it on valid/ready and
// returns ack_tgl only on the capture edge so din stays stable until then.
module powlib_cdc_hsrx
  import powlib_cdc_pkg::*;
#(
  parameter int           W    = 16,
  parameter int           S    = CDC_S_DEF,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_tgl,
  input  logic [W-1:0] din,
  output logic         ack_tgl,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic         busy
);

  logic         req_sync;
  logic         req_pend;
  logic         capture;

  cdc_state_e   state_q,    state_d;
  logic         req_seen_q, req_seen_d;
  logic         ack_q,      ack_d;
  logic [W-1:0] dout_q,     dout_d;

  powlib_cdc_sync #(
    .S (S)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_tgl),
    .q   (req_sync)
  );

  assign req_pend = req_sync ^ req_seen_q;

  // Next-state logic: capture when empty, or when the held word is taken
  // in the same cycle so back-to-back words flow with no bubble.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    dout_d     = dout_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_pend) begin
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (dout_rdy) begin
          if (req_pend) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      dout_d     = din;
      req_seen_d = req_sync;
      ack_d      = ~ack_q;
      state_d    = HOLD;
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= INIT;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
    end
  end

  assign ack_tgl  = ack_q;
  assign dout     = dout_q;
  assign dout_vld = (state_q == HOLD);
  assign busy     = req_pend | dout_vld;

endmodule

// File: tb/tb_powlib_cdc_hsrx.sv
// Bench for powlib_cdc_hsrx: directed sender steps, scoreboard of sent words.
module tb_powlib_cdc_hsrx;

  localparam int         W    = 8;
  localparam int         S    = 2;
  localparam logic [7:0] INIT = 8'hFF;

  logic         clk;
  logic         rst;
  logic         req_tgl;
  logic [W-1:0] din;
  logic         ack_tgl;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         busy;

  int           n_compared;
  int           n_mismatched;
  int           n_recv;
  logic [W-1:0] sb[$];
  logic         sb_on;
  logic         rand_rdy;

  powlib_cdc_hsrx #(
    .W    (W),
    .S    (S),
    .INIT (INIT)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_tgl  (req_tgl),
    .din      (din),
    .ack_tgl  (ack_tgl),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy)
  );

  // Free-running receive-domain clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample outputs at negedge (scoreboard pop if a word is
  // accepted), then return just after the posedge for the next drive.
  task automatic cycle();
    logic [W-1:0] exp_w;
    @(negedge clk);
    if (sb_on && dout_vld) begin
      checkOutput("busy_while_vld", busy, 1);
    end
    if (sb_on && dout_vld && dout_rdy) begin
      if (sb.size() != 0) exp_w = sb.pop_front();
      else                exp_w = 'x;
      checkOutput("sb_word", dout, exp_w);
      n_recv++;
    end
    @(posedge clk);
    #1;
    if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic waitAck(input string tag, input logic target);
    int n = 0;
    while (ack_tgl !== target && n < 200) begin
      cycle();
      n++;
    end
    checkOutput(tag, ack_tgl, target);
  endtask

  // Sender: wait until the previous transfer is acknowledged, then
  // present the word and toggle the request.
  task automatic applyStimulus(input logic [W-1:0] data);
    waitAck("send_ack_wait", req_tgl);
    din     = data;
    req_tgl = ~req_tgl;
    sb.push_back(data);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      cycle();
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  task automatic edgeStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int changes;
    int base;

    n_compared   = 0;
    n_mismatched = 0;
    n_recv       = 0;
    sb_on        = 1'b0;
    rand_rdy     = 1'b0;
    rst          = 1'b0;
    req_tgl      = 1'b0;
    din          = '0;
    dout_rdy     = 1'b0;

    // Reset values
    edgeStep();
    edgeStep();
    checkOutput("rst_dout", dout, INIT);
    checkOutput("rst_vld", dout_vld, 0);
    checkOutput("rst_ack", ack_tgl, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sync", u_dut.u_req_sync.sync_q, 0);
    rst = 1'b1;
    edgeStep();

    // Single transfer with exact latency
    din     = 8'hA5;
    req_tgl = 1'b1;
    edgeStep();
    checkOutput("lat_edge0_vld", dout_vld, 0);
    edgeStep();
    checkOutput("lat_edge1_vld", dout_vld, 0);
    checkOutput("lat_edge1_ack", ack_tgl, 0);
    edgeStep();
    checkOutput("lat_edge2_vld", dout_vld, 1);
    checkOutput("lat_edge2_ack", ack_tgl, 1);
    checkOutput("lat_edge2_dout", dout, 8'hA5);
    dout_rdy = 1'b1;
    edgeStep();
    checkOutput("single_drop_vld", dout_vld, 0);
    checkOutput("single_idle_busy", busy, 0);
    dout_rdy = 1'b0;

    // Backpressure
    din     = 8'h11;
    req_tgl = ~req_tgl;
    waitAck("bp_first_ack", 1'b0);
    checkOutput("bp_first_dout", dout, 8'h11);
    checkOutput("bp_first_vld", dout_vld, 1);
    din     = 8'h22;
    req_tgl = ~req_tgl;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ack_tgl !== 1'b0 || dout !== 8'h11 || dout_vld !== 1'b1) changes++;
    end
    checkOutput("bp_held_20", changes, 0);
    checkOutput("bp_busy", busy, 1);
    dout_rdy = 1'b1;
    edgeStep();
    checkOutput("bp_swap_dout", dout, 8'h22);
    checkOutput("bp_swap_vld", dout_vld, 1);
    checkOutput("bp_swap_ack", ack_tgl, 1);
    edgeStep();
    checkOutput("bp_end_vld", dout_vld, 0);
    dout_rdy = 1'b0;

    // Reset sender and receiver together before streaming
    rst     = 1'b0;
    req_tgl = 1'b0;
    din     = '0;
    edgeStep();
    rst = 1'b1;
    edgeStep();
    checkOutput("rerst_ack", ack_tgl, 0);

    // Streaming 16 words with dout_rdy=1
    sb_on    = 1'b1;
    dout_rdy = 1'b1;
    base     = n_recv;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i));
    end
    drain("stream_drain");
    for (int i = 0; i < 4; i++) cycle();
    checkOutput("stream_count", n_recv - base, 16);
    checkOutput("stream_ack_end", ack_tgl, 0);

    // Random backpressure, random data
    rand_rdy = 1'b1;
    base     = n_recv;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
    end
    drain("rand_drain");
    rand_rdy = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    checkOutput("rand_count", n_recv - base, 1000);
    checkOutput("rand_idle_vld", dout_vld, 0);
    checkOutput("rand_idle_busy", busy, 0);
    dout_rdy = 1'b0;
    sb_on    = 1'b0;

    // Async reset during HOLD, sender keeps req_tgl=1
    din     = 8'h5A;
    req_tgl = ~req_tgl;
    waitAck("ar_ack", req_tgl);
    checkOutput("ar_hold_dout", dout, 8'h5A);
    checkOutput("ar_hold_vld", dout_vld, 1);
    checkOutput("ar_req_high", req_tgl, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_async_vld", dout_vld, 0);
    checkOutput("ar_async_dout", dout, INIT);
    checkOutput("ar_async_ack", ack_tgl, 0);
    checkOutput("ar_async_sync", u_dut.u_req_sync.sync_q, 0);
    edgeStep();
    rst = 1'b1;
    edgeStep();
    checkOutput("ar_post_e0_vld", dout_vld, 0);
    edgeStep();
    checkOutput("ar_post_e1_vld", dout_vld, 0);
    edgeStep();
    checkOutput("ar_post_e2_vld", dout_vld, 1);
    checkOutput("ar_post_e2_dout", dout, 8'h5A);
    checkOutput("ar_post_e2_ack", ack_tgl, 1);
    dout_rdy = 1'b1;
    edgeStep();
    checkOutput("ar_final_vld", dout_vld, 0);
    checkOutput("ar_final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
